hdmi_out_960_to_1920: RTL
=========================

# hdmi_out_960_to_1920

2x nearest-neighbour upscaler for the HDMI display path: accepts a 960x540 RGB888 stream and emits a 1920x1080 stream by repeating each pixel twice horizontally and each line twice vertically. It is the reverse of the 1920->960 input decimator. A half-resolution processed image is expanded back to native HDMI resolution ahead of the output timing/VDMA stage. Two ping-pong line banks decouple the write side from the output side, with valid/ready back-pressure on both sides.

## Interface
- IN_WIDTH, 960, input pixels per line (output line = 2*IN_WIDTH)
- IN_HEIGH, 540, input lines per frame (output frame = 2*IN_HEIGH lines)
- clk  in  1  pixel clock; all logic single-clock
- rst  in  1  synchronous, active-high reset
- data_in_r / data_in_g / data_in_b  in  8 each  input pixel
- data_in_valid  in  1  input pixel present
- data_in_ready  out  1  block can accept; transfer when valid && ready
- data_out_r / data_out_g / data_out_b  out  8 each  output pixel (registered)
- data_out_valid  out  1  output pixel present (registered)
- data_out_ready  in  1  downstream accepts; transfer when valid && ready
- data_out_sof  out  1  qualifies first pixel of output frame
- data_out_eol  out  1  qualifies last pixel of each output line

## Operation
- Storage: 2 banks x IN_WIDTH x 24 bit, combinational read (LUT RAM or registers); per-bank `full` flag and `sof` tag.
- Write side: counters wr_x (0..IN_WIDTH-1), wr_y (0..IN_HEIGH-1), wr_bank.
  - data_in_ready = !full[wr_bank].
  - On accept: write {r,g,b} to bank[wr_bank][wr_x]; wr_x++.
  - On wr_x == IN_WIDTH-1: wr_x <= 0, full[wr_bank] <= 1, sof[wr_bank] <= (wr_y == 0), wr_bank toggles, wr_y wraps at IN_HEIGH-1.
- Read FSM, states IDLE and PLAY; counters rd_x (0..IN_WIDTH-1), px (0/1 horizontal repeat), ly (0/1 vertical repeat), rd_bank.
  - IDLE: if full[rd_bank] and output register free (!data_out_valid || data_out_ready), load pixel rd_x=0, px=0, ly=0 -> PLAY.
  - PLAY: on each free output-register slot, advance (px, rd_x, ly) in that nesting order and load bank[rd_bank][rd_x].
  - After loading px=1, rd_x=IN_WIDTH-1:
    - ly=0: ly <= 1, rd_x <= 0, stay in PLAY.
    - ly=1: full[rd_bank] <= 0, rd_bank toggles, ly <= 0. Continue in PLAY if the other bank is full, else go to IDLE.
  - Bank release has no gap: the next line starts on the following free slot.
- data_out_sof = (px=0 && rd_x=0 && ly=0 && sof[rd_bank]), registered with the pixel.
- data_out_eol = (px=1 && rd_x=IN_WIDTH-1), registered with the pixel; asserted on both repeated lines.
- Output register holds its value while data_out_valid && !data_out_ready. It clears data_out_valid when it is free and no pixel is available.
- The writer only touches a non-full bank and the reader only a full bank. Set and clear of different banks in the same cycle are independent; set and clear of the same bank in the same cycle cannot occur.

## Timing
- Reset values: data_in_ready 1 after the first cycle out of reset (both banks empty); data_out_valid 0; data_out_r/g/b 0; data_out_sof 0; data_out_eol 0. All counters, FSM (IDLE), banks, flags and tags cleared.
- Reset mid-frame drops partial lines and any buffered lines. The output restarts only after a full new input line.
- Latency: last pixel of an input line accepted at edge N -> full set at N -> first output pixel valid after edge N+1 (if out_ready held 1).
- Throughput: 4*IN_WIDTH output cycles per input line at steady state.
  - With both banks full, data_in_ready = 0; the input stalls until a bank is released.
  - The first line needs IN_WIDTH input cycles to fill.
- With data_out_ready = 1 continuously, output is gap-free while banks stay fed.

## Test plan
- IN_WIDTH=4, IN_HEIGH=2; line0 = pixels 1,2,3,4, out_ready=1 -> output 1,1,2,2,3,3,4,4 twice (16 pixels). sof on the first pixel only; eol on pixel 8 and pixel 16. First valid 2 cycles after the last input accept.
- Continuous input, 3 lines, out_ready=1 -> data_in_ready drops while both banks are full. No pixel is lost or duplicated beyond 2x2. Per line, output order is L0 x2, L1 x2, L2 x2.
- Random out_ready (50%) -> data_out_* stable while valid && !ready. Sequence identical to the no-stall case.
- Default 960x540, full frame -> exactly 1080 eol pulses of 1920 pixels each. One sof at the frame start; the next frame's first line carries sof again.
- Assert rst mid-line (after 500 input pixels) -> next cycle valid=0, sof/eol=0. The first output after reset comes only after 960 fresh input pixels.
- Input stalls (valid gaps) during playback -> the output pauses only on empty banks. The output line is never split across banks.

Source files
------------

// File: rtl/hdmi_out_960_to_1920_if.sv
// Pixel stream bundle for the 2x upscaler.
// Input stream uses valid/ready; the output stream adds sof/eol frame markers.
interface hdmi_out_960_to_1920_if;
   logic [7:0] data_in_r;
   logic [7:0] data_in_g;
   logic [7:0] data_in_b;
   logic       data_in_valid;
   logic       data_in_ready;
   logic [7:0] data_out_r;
   logic [7:0] data_out_g;
   logic [7:0] data_out_b;
   logic       data_out_valid;
   logic       data_out_ready;
   logic       data_out_sof;
   logic       data_out_eol;

   modport master (
      output data_in_r, data_in_g, data_in_b, data_in_valid, data_out_ready,
      input  data_in_ready, data_out_r, data_out_g, data_out_b,
             data_out_valid, data_out_sof, data_out_eol
   );

   modport slave (
      input  data_in_r, data_in_g, data_in_b, data_in_valid, data_out_ready,
      output data_in_ready, data_out_r, data_out_g, data_out_b,
             data_out_valid, data_out_sof, data_out_eol
   );
endinterface

// File: rtl/hdmi_out_960_to_1920.sv
// 2x nearest-neighbour upscaler: each input pixel is emitted twice per line and
// each line twice per frame, buffered through two ping-pong line banks.
//
// state | meaning
// IDLE  | no full bank at rd_bank; output register drains
// PLAY  | streaming the bank at rd_bank (pixel x2, line x2)
module hdmi_out_960_to_1920 #(
   parameter int IN_WIDTH = 960,
   parameter int IN_HEIGH = 540
) (
   input logic                   clk,
   input logic                   rst,
   hdmi_out_960_to_1920_if.slave vid
);
   localparam int XW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int YW = (IN_HEIGH > 1) ? $clog2(IN_HEIGH) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGH - 1);

   typedef enum logic {IDLE, PLAY} rd_state_t;

   logic [23:0]   line_mem [2][IN_WIDTH];
   logic [1:0]    full;
   logic [1:0]    sof_tag;
   logic [1:0]    full_set;
   logic [1:0]    full_clr;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic          wr_bank;
   logic          wr_acc;
   logic          wr_last;

   rd_state_t     state;
   rd_state_t     state_d;
   logic [XW-1:0] rd_x;
   logic [XW-1:0] rd_x_d;
   logic          px;
   logic          px_d;
   logic          ly;
   logic          ly_d;
   logic          rd_bank;
   logic          rd_bank_d;
   logic          out_free;
   logic          load;
   logic          release_bank;
   logic [23:0]   rd_pix;

   assign vid.data_in_ready = !full[wr_bank];
   assign wr_acc   = vid.data_in_valid && !full[wr_bank];
   assign wr_last  = wr_acc && (wr_x == X_LAST);
   assign out_free = !vid.data_out_valid || vid.data_out_ready;
   assign rd_pix   = line_mem[rd_bank][rd_x];

   assign full_set = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign full_clr = release_bank ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_x    <= '0;
         wr_y    <= '0;
         wr_bank <= 1'b0;
         sof_tag <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
               line_mem[b][i] <= '0;
            end
         end
      end else if (wr_acc) begin
         line_mem[wr_bank][wr_x] <= {vid.data_in_r, vid.data_in_g, vid.data_in_b};
         if (wr_last) begin
            wr_x             <= '0;
            sof_tag[wr_bank] <= (wr_y == '0);
            wr_bank          <= !wr_bank;
            wr_y             <= (wr_y == Y_LAST) ? '0 : wr_y + 1'b1;
         end else begin
            wr_x <= wr_x + 1'b1;
         end
      end
   end

   // Writer only sets a non-full bank, reader only clears a full one, so the
   // two masks never overlap on the same bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
      end else begin
         full <= (full | full_set) & ~full_clr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_x    <= '0;
         px      <= 1'b0;
         ly      <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         state   <= state_d;
         rd_x    <= rd_x_d;
         px      <= px_d;
         ly      <= ly_d;
         rd_bank <= rd_bank_d;
      end
   end

   always_comb begin
      state_d      = state;
      rd_x_d       = rd_x;
      px_d         = px;
      ly_d         = ly;
      rd_bank_d    = rd_bank;
      load         = 1'b0;
      release_bank = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank] && out_free) begin
               load    = 1'b1;
               px_d    = 1'b1;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (out_free) begin
               load = 1'b1;
               if (!px) begin
                  px_d = 1'b1;
               end else begin
                  px_d = 1'b0;
                  if (rd_x != X_LAST) begin
                     rd_x_d = rd_x + 1'b1;
                  end else begin
                     rd_x_d = '0;
                     if (!ly) begin
                        ly_d = 1'b1;
                     end else begin
                        ly_d         = 1'b0;
                        release_bank = 1'b1;
                        rd_bank_d    = !rd_bank;
                        state_d      = full[!rd_bank] ? PLAY : IDLE;
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vid.data_out_valid <= 1'b0;
         vid.data_out_r     <= '0;
         vid.data_out_g     <= '0;
         vid.data_out_b     <= '0;
         vid.data_out_sof   <= 1'b0;
         vid.data_out_eol   <= 1'b0;
      end else if (load) begin
         vid.data_out_valid <= 1'b1;
         {vid.data_out_r, vid.data_out_g, vid.data_out_b} <= rd_pix;
         vid.data_out_sof   <= !px && (rd_x == '0) && !ly && sof_tag[rd_bank];
         vid.data_out_eol   <= px && (rd_x == X_LAST);
      end else if (out_free) begin
         vid.data_out_valid <= 1'b0;
         vid.data_out_sof   <= 1'b0;
         vid.data_out_eol   <= 1'b0;
      end
   end
endmodule
